data_memory_responder: RTL and testbench

//  Memory-side responder for the CPU's load/store (data) port: accepts one load or store

---
 rtl/data_memory_responder.sv | 176 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-port memory responder: one request per cycle, fixed-latency in-order
// responses, RV32I byte/half/word lane selection and load extension.
module data_memory_responder #(
  parameter int unsigned SIZE_OF_MEMORY  = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = (SIZE_OF_MEMORY > 1) ? $clog2(SIZE_OF_MEMORY) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

  logic [31:0]   mem_q [SIZE_OF_MEMORY];

  logic [CW-1:0] cnt_q, cnt_d;

  logic          pv_q [LATENCY];
  logic          pe_q [LATENCY];
  logic [31:0]   pd_q [LATENCY];

  logic [31:0]   fd_q [MAX_OUTSTANDING];
  logic          fe_q [MAX_OUTSTANDING];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] fc_q;

  logic          req_fire, rsp_fire, push;
  logic [29:0]   offw;
  logic [IW-1:0] idx;
  logic          oor, mis, bad_sz, err;
  logic [31:0]   word, ld_data, wr_word;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  // count never drops in the same cycle it is checked, so no rsp_ready->req_ready path
  assign req_ready = !rst && (cnt_q < CMAX);
  assign req_fire  = req_valid && req_ready;
  assign rsp_valid = (fc_q != '0);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fd_q[rp_q] : '0;
  assign rsp_err   = rsp_valid && fe_q[rp_q];
  assign push      = pv_q[LATENCY-1];

  // BASE_ADDR is word aligned, so word offset comes straight from bits [31:2]
  assign offw = req_addr[31:2] - BASE_ADDR[31:2];
  assign idx  = offw[IW-1:0];
  assign oor  = (req_addr < BASE_ADDR) ||
                ({2'b00, offw} >= 32'(SIZE_OF_MEMORY));
  assign err  = oor || mis || bad_sz;
  assign word = mem_q[idx];

  // access size decode and alignment check
  always_comb begin
    mis    = 1'b0;
    bad_sz = 1'b0;
    case (req_funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = req_addr[0];
      2'b10:   mis = |req_addr[1:0];
      default: bad_sz = 1'b1;
    endcase
  end

  // load lane select and extension; stores and errors return zero
  always_comb begin
    ld_b    = word[{req_addr[1:0], 3'b000} +: 8];
    ld_h    = req_addr[1] ? word[31:16] : word[15:0];
    ld_data = '0;
    if (!req_we && !err) begin
      case (req_funct3[1:0])
        2'b00:   ld_data = req_funct3[2] ? {24'h0, ld_b}
                                         : {{24{ld_b[7]}}, ld_b};
        2'b01:   ld_data = req_funct3[2] ? {16'h0, ld_h}
                                         : {{16{ld_h[15]}}, ld_h};
        2'b10:   ld_data = word;
        default: ld_data = '0;
      endcase
    end
  end

  // store merge: only the addressed lanes change
  always_comb begin
    wr_word = word;
    case (req_funct3[1:0])
      2'b00:   wr_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      2'b01:   wr_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      2'b10:   wr_word = req_wdata;
      default: wr_word = word;
    endcase
  end

  // outstanding count next state
  always_comb begin
    cnt_d = cnt_q;
    if (req_fire && !rsp_fire) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!req_fire && rsp_fire) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // memory array keeps contents across reset
  always_ff @(posedge clk) begin
    if (req_fire && req_we && !err) begin
      mem_q[idx] <= wr_word;
    end
  end

  // outstanding count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // fixed-latency result pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pe_q[i] <= 1'b0;
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= req_fire;
      pe_q[0] <= err;
      pd_q[0] <= ld_data;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  // response FIFO; occupancy is bounded by the outstanding count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fd_q[i] <= '0;
        fe_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fd_q[wp_q] <= pd_q[LATENCY-1];
        fe_q[wp_q] <= pe_q[LATENCY-1];
        wp_q       <= (wp_q == PMAX) ? '0 : wp_q + PW'(1);
      end
      if (rsp_fire) begin
        rp_q <= (rp_q == PMAX) ? '0 : rp_q + PW'(1);
      end
      fc_q <= fc_q + CW'(push) - CW'(rsp_fire);
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: vector table for single
// transactions plus sequences for back-pressure and mid-stream reset.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int total  = 0;
  int passed = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl [23];

  data_memory_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output logic [31:0] rd, output logic e,
                        output int lat);
    int n;
    rd  = '0;
    e   = 1'b0;
    lat = -1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_wdata  = wd;
    req_funct3 = f3;
    rsp_ready  = 1'b1;
    n = 0;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        rd  = rsp_rdata;
        e   = rsp_err;
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd, hold;
    logic        e, first, stable;
    int          lat, acc, got, stale;

    tbl = '{
      '{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0},
      '{1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0},
      '{1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 1'b0},
      '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 1'b0},
      '{1'b1, 32'h11,  32'h123456AA, 3'b000, 32'h0,        1'b0},
      '{1'b1, 32'h12,  32'h0000CAFE, 3'b001, 32'h0,        1'b0},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'hCAFEAAEF, 1'b0},
      '{1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1},
      '{1'b1, 32'h11,  32'h0000FFFF, 3'b001, 32'h0,        1'b1},
      '{1'b0, 32'h400, 32'h0,        3'b010, 32'h0,        1'b1},
      '{1'b1, 32'h400, 32'h00000055, 3'b000, 32'h0,        1'b1},
      '{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1},
      '{1'b0, 32'h10,  32'h0,        3'b010, 32'hCAFEAAEF, 1'b0},
      '{1'b1, 32'h3FC, 32'h01020304, 3'b010, 32'h0,        1'b0},
      '{1'b0, 32'h3FD, 32'h0,        3'b000, 32'h00000003, 1'b0},
      '{1'b0, 32'h3FE, 32'h0,        3'b001, 32'h00000102, 1'b0},
      '{1'b1, 32'h20,  32'h00000080, 3'b000, 32'h0,        1'b0},
      '{1'b0, 32'h20,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0},
      '{1'b0, 32'h20,  32'h0,        3'b100, 32'h00000080, 1'b0},
      '{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFCAFE, 1'b0},
      '{1'b0, 32'h11,  32'h0,        3'b000, 32'hFFFFFFAA, 1'b0}
    };

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = 3'b010;
    rsp_ready  = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err",   32'(rsp_err), 32'h0);
    rst = 1'b0;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 23; i++) begin
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    for (int k = 0; k < 6; k++) begin
      do_req(1'b1, 32'h40 + 32'(4 * k), 32'hA5000000 | 32'(k), 3'b010,
             rd, e, lat);
      chk($sformatf("prep%0d_err", k), 32'(e), 32'h0);
    end

    acc    = 0;
    got    = 0;
    first  = 1'b0;
    stable = 1'b1;
    hold   = '0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      req_valid  = (acc < 6);
      req_we     = 1'b0;
      req_addr   = 32'h40 + 32'(4 * acc);
      req_funct3 = 3'b010;
      rsp_ready  = 1'b0;
      #1;
      if (rsp_valid) begin
        if (!first) begin
          hold  = rsp_rdata;
          first = 1'b1;
        end else if (rsp_rdata !== hold) begin
          stable = 1'b0;
        end
      end
      if (req_valid && req_ready) acc++;
    end
    chk("stall_accepted", 32'(acc), 32'd4);
    chk("stall_req_ready", 32'(req_ready), 32'h0);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("stall_stable", 32'(stable), 32'h1);
    chk("stall_head", hold, 32'hA5000000);

    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      req_valid = (acc < 6);
      req_addr  = 32'h40 + 32'(4 * acc);
      rsp_ready = 1'b1;
      #1;
      if (rsp_valid) begin
        chk($sformatf("drain%0d_rdata", got), rsp_rdata,
            32'hA5000000 | 32'(got));
        chk($sformatf("drain%0d_err", got), 32'(rsp_err), 32'h0);
        got++;
      end
      if (req_valid && req_ready) acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("drain_count", 32'(got), 32'd6);
    chk("drain_accepted", 32'(acc), 32'd6);

    acc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_addr   = 32'h10;
      req_funct3 = 3'b010;
      rsp_ready  = 1'b1;
      #1;
      if (req_ready) acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("inflight_accepted", 32'(acc), 32'd3);
    chk("pre_reset_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(req_ready), 32'h1);
    stale = 0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) stale++;
    end
    chk("midrst_stale", 32'(stale), 32'h0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, e, lat);
    chk("post_rst_rdata", rd, 32'hCAFEAAEF);
    chk("post_rst_err", 32'(e), 32'h0);
    chk("post_rst_latency", 32'(lat), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
